// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// image framing constants and a small byte-fold helper.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_LOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int CSUM_BYTES     = 1;
    localparam int BYTES_PER_WORD = 4;

    // XOR of the four bytes of a word; the image checksum is the fold of these
    function automatic logic [7:0] xor_word(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the master view; the byte source / memory side uses slave.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Big-endian byte-to-word packer: collects bytes MSB first and flags the
// cycle in which the last byte of a word is accepted, presenting the full word.
module byte_word_packer
    import imem_boot_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    // Only the first three bytes need storage; the fourth comes straight from the input
    logic [WORD_W-9:0] r_shift;
    logic [1:0]        r_cnt;

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_byte_valid) begin
            r_shift <= {r_shift[WORD_W-17:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte image, writes it
// word by word into instruction memory and releases the core once it verifies.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    imem_boot_loader_if.master    bus,
    output logic                  o_core_hold,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_n;
    logic [ADDR_W:0]     r_word_cnt;
    logic [7:0]          r_csum;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [WORD_W-1:0]   r_imem_wdata;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_clear;
    logic                w_load_byte;
    logic                w_word_valid;
    logic [WORD_W-1:0]   w_word;
    logic [15:0]         w_n_full;
    logic                w_last_word;

    // No byte is taken in the cycle the assembled word is being written
    assign w_in_ready  = (r_state == ST_HDR_HI) || (r_state == ST_HDR_LO) ||
                         (r_state == ST_CSUM)   ||
                         ((r_state == ST_LOAD) && !r_imem_we);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_load_byte = w_accept && (r_state == ST_LOAD);
    assign w_n_full    = {r_n[15:8], bus.in_data};
    assign w_last_word = (16'(r_word_cnt) + 16'd1) == r_n;

    byte_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_reset),
        .i_clear      (w_clear),
        .i_byte_valid (w_load_byte),
        .i_byte       (bus.in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    w_state_next = ST_HDR_HI;
                    w_clear      = 1'b1;
                end
            end
            ST_HDR_HI: begin
                if (w_accept) w_state_next = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (w_accept) begin
                    if (32'(w_n_full) > DEPTH)  w_state_next = ST_ERROR;
                    else if (w_n_full == 16'd0) w_state_next = ST_CSUM;
                    else                        w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (r_imem_we && w_last_word) w_state_next = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_accept) begin
                    w_state_next = (bus.in_data == r_csum) ? ST_DONE : ST_ERROR;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_n          <= '0;
            r_word_cnt   <= '0;
            r_csum       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= w_word_valid;
            if (w_word_valid) begin
                r_imem_addr  <= r_word_cnt[ADDR_W-1:0];
                r_imem_wdata <= w_word;
            end
            if (w_clear) begin
                r_n        <= '0;
                r_word_cnt <= '0;
                r_csum     <= '0;
            end else begin
                if (w_accept && (r_state == ST_HDR_HI)) r_n[15:8] <= bus.in_data;
                if (w_accept && (r_state == ST_HDR_LO)) r_n[7:0]  <= bus.in_data;
                if (w_load_byte) r_csum <= r_csum ^ bus.in_data;
                if (r_imem_we)   r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;

    assign o_core_hold = (r_state != ST_DONE);
    assign o_done      = (r_state == ST_DONE);
    assign o_error     = (r_state == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: scoreboarded memory writes plus
// per-scenario status checks.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int ADDR_W = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic core_hold, done, error;

    imem_boot_loader_if #(.ADDR_W(ADDR_W), .WORD_W(32)) bus();

    imem_boot_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
        .i_clk       (clk),
        .i_reset     (reset_n),
        .i_start     (start),
        .bus         (bus),
        .o_core_hold (core_hold),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img_q[$];
    logic        prev_we = 1'b0;

    // Write scoreboard and single-cycle write-enable check
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                             bus.imem_addr, bus.imem_wdata, mon_e.addr, mon_e.data);
                end else begin
                    $display("write addr=%h data=%h ok", bus.imem_addr, bus.imem_wdata);
                end
            end
            checks++;
            if (prev_we === 1'b1) begin
                errors++;
                $display("FAIL we_width: imem_we high 2 consecutive cycles, required 1");
            end
        end
        prev_we = bus.imem_we;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_csum();
        logic [7:0] c = 8'h00;
        foreach (img_q[i]) c = c ^ xor_word(img_q[i]);
        return c;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n = 0;
        if (stall) begin
            bus.in_valid = 1'b0;
            while ($urandom_range(0, 1) == 1 && n < 8) begin
                @(negedge clk);
                n++;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_header(input int n);
        send_byte(8'((n >> 8) & 255), 1'b0);
        send_byte(8'(n & 255), 1'b0);
    endtask

    // Streams img_q; each word's write must appear one cycle after its last byte
    task automatic send_words(input bit stall);
        for (int w = 0; w < img_q.size(); w++) begin
            exp_q.push_back({8'(w), img_q[w]});
            for (int k = 3; k >= 0; k--) send_byte(img_q[w][k*8 +: 8], stall);
            checks++;
            if (bus.imem_we !== 1'b1) begin
                errors++;
                $display("FAIL write_latency: word %0d imem_we=%b, required 1", w, bus.imem_we);
            end
        end
    endtask

    task automatic fill_nominal();
        img_q.delete();
        img_q.push_back(32'h20080005);
        img_q.push_back(32'h01095020);
    endtask

    task automatic check_done_state(input string tag);
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_status: done=%b hold=%b error=%b ready=%b, required 1 0 0 0",
                     tag, done, core_hold, error, bus.in_ready);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: %0d pending, required 0", tag, exp_q.size());
        end
        $display("%s: done=%b hold=%b error=%b", tag, done, core_hold, error);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_hold, done, error}
            !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b, required 0 0 00 00000000 1 0 0",
                     bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_hold, done, error);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: ready=%b hold=%b done=%b, required 0 1 0",
                     bus.in_ready, core_hold, done);
        end
        $display("reset: hold=%b ready=%b", core_hold, bus.in_ready);
    endtask

    task automatic test_nominal();
        fill_nominal();
        pulse_start();
        send_header(2);
        send_words(1'b0);
        send_byte(model_csum(), 1'b0);
        check_done_state("nominal");
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0 || bus.imem_addr !== 8'h01 || bus.imem_wdata !== 32'h01095020) begin
            errors++;
            $display("FAIL write_port_hold: we=%b addr=%h data=%h, required 0 01 01095020",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
    endtask

    task automatic test_bad_csum();
        fill_nominal();
        pulse_start();
        send_header(2);
        send_words(1'b0);
        send_byte(8'h66, 1'b0);
        checks++;
        if (error !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bad_csum: error=%b hold=%b done=%b pending=%0d, required 1 1 0 0",
                     error, core_hold, done, exp_q.size());
        end
        $display("bad_csum: error=%b hold=%b", error, core_hold);
    endtask

    task automatic test_oversize();
        int w0 = writes_seen;
        pulse_start();
        checks++;
        if (error !== 1'b0 || core_hold !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_error: error=%b hold=%b, required 0 1", error, core_hold);
        end
        send_header(257);
        checks++;
        if (error !== 1'b1 || bus.in_ready !== 1'b0 || core_hold !== 1'b1) begin
            errors++;
            $display("FAIL oversize: error=%b ready=%b hold=%b, required 1 0 1",
                     error, bus.in_ready, core_hold);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || error !== 1'b1 || writes_seen != w0) begin
            errors++;
            $display("FAIL error_sticky: ready=%b error=%b writes=%0d, required 0 1 %0d",
                     bus.in_ready, error, writes_seen, w0);
        end
        bus.in_valid = 1'b0;
        $display("oversize: error=%b writes=%0d", error, writes_seen - w0);
    endtask

    task automatic test_empty();
        int w0 = writes_seen;
        img_q.delete();
        pulse_start();
        send_header(0);
        send_byte(8'h00, 1'b0);
        check_done_state("empty");
        checks++;
        if (writes_seen != w0) begin
            errors++;
            $display("FAIL empty_writes: got %0d, required 0", writes_seen - w0);
        end
    endtask

    task automatic test_stall();
        fill_nominal();
        pulse_start();
        send_header(2);
        send_words(1'b1);
        send_byte(model_csum(), 1'b1);
        check_done_state("stall");
    endtask

    task automatic test_reset_midload();
        fill_nominal();
        pulse_start();
        send_header(2);
        exp_q.push_back({8'h00, img_q[0]});
        for (int k = 3; k >= 0; k--) send_byte(img_q[0][k*8 +: 8], 1'b0);
        send_byte(img_q[1][31:24], 1'b0);
        send_byte(img_q[1][23:16], 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0 || bus.imem_we !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: ready=%b hold=%b done=%b we=%b, required 0 1 0 0",
                     bus.in_ready, core_hold, done, bus.imem_we);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_header(2);
        send_words(1'b0);
        send_byte(model_csum(), 1'b0);
        check_done_state("reload");
    endtask

    task automatic test_ignored_start();
        fill_nominal();
        pulse_start();
        send_header(2);
        exp_q.push_back({8'h00, img_q[0]});
        send_byte(img_q[0][31:24], 1'b0);
        send_byte(img_q[0][23:16], 1'b0);
        pulse_start();
        send_byte(img_q[0][15:8], 1'b0);
        send_byte(img_q[0][7:0], 1'b0);
        exp_q.push_back({8'h01, img_q[1]});
        for (int k = 3; k >= 0; k--) send_byte(img_q[1][k*8 +: 8], 1'b0);
        send_byte(model_csum(), 1'b0);
        check_done_state("ignored_start");
    endtask

    task automatic test_full_depth();
        img_q.delete();
        for (int i = 0; i < 256; i++) img_q.push_back($urandom());
        pulse_start();
        checks++;
        if (core_hold !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: hold=%b done=%b ready=%b, required 1 0 1",
                     core_hold, done, bus.in_ready);
        end
        send_header(256);
        send_words(1'b0);
        checks++;
        if (bus.imem_addr !== 8'hFF || bus.imem_wdata !== img_q[255]) begin
            errors++;
            $display("FAIL last_write: addr=%h data=%h, required ff %h",
                     bus.imem_addr, bus.imem_wdata, img_q[255]);
        end
        send_byte(model_csum(), 1'b0);
        check_done_state("full_depth");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_nominal();
        test_bad_csum();
        test_oversize();
        test_empty();
        test_stall();
        test_reset_midload();
        test_ignored_start();
        test_full_depth();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
